// File: rtl/lsu_mem_stage.sv
// RV32 load/store MEM stage over a req/gnt/rvalid data bus with variable latency.
// Stalls while an access is in flight, faults on misalignment or bus timeout.
`timescale 1ns/1ps
module lsu_mem_stage #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          MISALIGN_FAULT = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           alu_result_e_i,
  input  logic [31:0]           alu_calculation_e_i,
  input  logic [3:0]            dmem_type_e_i,
  input  logic [31:0]           rs2_e_i,
  input  logic [31:0]           extended_imm_e_i,
  input  logic [31:0]           pc_plus_e_i,
  input  logic                  reg_write_en_e_i,
  input  logic [4:0]            rd_idx_e_i,
  input  logic [3:0]            result_src_e_i,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [3:0]            bus_be_o,
  output logic [31:0]           bus_wdata_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_rvalid_i,
  input  logic [31:0]           bus_rdata_i,
  output logic                  stall_o,
  output logic                  fault_o,
  output logic [31:0]           fault_addr_o,
  output logic [31:0]           mem_read_data_m_o,
  output logic [31:0]           alu_result_m_o,
  output logic [31:0]           extended_imm_m_o,
  output logic [31:0]           pc_plus_m_o,
  output logic                  reg_write_en_m_o,
  output logic [4:0]            rd_idx_m_o,
  output logic [3:0]            result_src_m_o,
  output logic [31:0]           bypass_m_o
);

  localparam logic [3:0] DMEM_NO  = 4'd0;
  localparam logic [3:0] DMEM_LB  = 4'd1;
  localparam logic [3:0] DMEM_LH  = 4'd2;
  localparam logic [3:0] DMEM_LW  = 4'd3;
  localparam logic [3:0] DMEM_LBU = 4'd4;
  localparam logic [3:0] DMEM_LHU = 4'd5;
  localparam logic [3:0] DMEM_SB  = 4'd6;
  localparam logic [3:0] DMEM_SH  = 4'd7;
  localparam logic [3:0] DMEM_SW  = 4'd8;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StResp  = 2'd1;
  localparam logic [1:0] StFault = 2'd2;

  localparam int unsigned   CntW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] ToLimit = CntW'(TIMEOUT_CYCLES);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]     fault_addr_q, fault_addr_d;
  logic [31:0]     mem_read_data_q, alu_result_q, extended_imm_q, pc_plus_q;
  logic            reg_write_en_q;
  logic [4:0]      rd_idx_q;
  logic [3:0]      result_src_q;

  logic        is_load, is_store, mem_op, size_half, size_word, misalign, fault_now;
  logic        timeout_hit, bubble, load_fire;
  logic [1:0]  off;
  logic [31:0] addr, load_ext, load_bp;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign addr      = alu_calculation_e_i;
  assign is_load   = (dmem_type_e_i == DMEM_LB) || (dmem_type_e_i == DMEM_LH) ||
                     (dmem_type_e_i == DMEM_LW) || (dmem_type_e_i == DMEM_LBU) ||
                     (dmem_type_e_i == DMEM_LHU);
  assign is_store  = (dmem_type_e_i == DMEM_SB) || (dmem_type_e_i == DMEM_SH) ||
                     (dmem_type_e_i == DMEM_SW);
  assign mem_op    = (dmem_type_e_i != DMEM_NO) && (is_load || is_store);
  assign size_half = (dmem_type_e_i == DMEM_LH) || (dmem_type_e_i == DMEM_LHU) ||
                     (dmem_type_e_i == DMEM_SH);
  assign size_word = (dmem_type_e_i == DMEM_LW) || (dmem_type_e_i == DMEM_SW);
  assign misalign  = (size_half && addr[0]) || (size_word && (addr[1:0] != 2'b00));
  assign fault_now = MISALIGN_FAULT && misalign;

  // Lane offset; halfword/word accesses are forced aligned when misalignment does not fault.
  always_comb begin
    if (size_word)      off = 2'b00;
    else if (size_half) off = {addr[1], 1'b0};
    else                off = addr[1:0];
  end

  always_comb begin
    if (size_word)      bus_be_o = 4'b1111;
    else if (size_half) bus_be_o = off[1] ? 4'b1100 : 4'b0011;
    else                bus_be_o = 4'b0001 << off;
  end

  always_comb begin
    if (size_word)      bus_wdata_o = rs2_e_i;
    else if (size_half) bus_wdata_o = {2{rs2_e_i[15:0]}};
    else                bus_wdata_o = {4{rs2_e_i[7:0]}};
  end

  assign bus_we_o   = is_store;
  assign bus_addr_o = ADDR_WIDTH'({addr[31:2], 2'b00});

  always_comb begin
    unique case (off)
      2'd0:    load_byte = bus_rdata_i[7:0];
      2'd1:    load_byte = bus_rdata_i[15:8];
      2'd2:    load_byte = bus_rdata_i[23:16];
      default: load_byte = bus_rdata_i[31:24];
    endcase
    load_half = off[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (dmem_type_e_i)
      DMEM_LB:  load_ext = {{24{load_byte[7]}}, load_byte};
      DMEM_LBU: load_ext = {24'd0, load_byte};
      DMEM_LH:  load_ext = {{16{load_half[15]}}, load_half};
      DMEM_LHU: load_ext = {16'd0, load_half};
      DMEM_LW:  load_ext = bus_rdata_i;
      default:  load_ext = 32'd0;
    endcase
  end

  assign cnt_inc     = cnt_q + CntW'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == ToLimit);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fault_addr_d = fault_addr_q;
    bus_req_o    = 1'b0;
    stall_o      = 1'b0;
    fault_o      = 1'b0;
    bubble       = 1'b0;
    load_fire    = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (mem_op) begin
          if (fault_now) begin
            // Hold the instruction one cycle; the FAULT cycle then drops it.
            stall_o      = 1'b1;
            state_d      = StFault;
            fault_addr_d = addr;
          end else begin
            bus_req_o = 1'b1;
            if (bus_gnt_i) begin
              if (is_load) begin
                stall_o = 1'b1;
                state_d = StResp;
              end
            end else begin
              stall_o = 1'b1;
              if (timeout_hit) begin
                state_d      = StFault;
                fault_addr_d = addr;
              end else begin
                cnt_d = cnt_inc;
              end
            end
          end
        end
      end
      StResp: begin
        if (bus_rvalid_i) begin
          load_fire = 1'b1;
          state_d   = StIdle;
          cnt_d     = '0;
        end else begin
          stall_o = 1'b1;
          if (timeout_hit) begin
            state_d      = StFault;
            fault_addr_d = addr;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StFault: begin
        fault_o = 1'b1;
        bubble  = 1'b1;
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      fault_addr_q    <= 32'd0;
      mem_read_data_q <= 32'd0;
      alu_result_q    <= 32'd0;
      extended_imm_q  <= 32'd0;
      pc_plus_q       <= 32'd0;
      reg_write_en_q  <= 1'b0;
      rd_idx_q        <= 5'd0;
      result_src_q    <= 4'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fault_addr_q <= fault_addr_d;
      if (stall_o || bubble) begin
        reg_write_en_q <= 1'b0;
        result_src_q   <= 4'd0;
      end else begin
        alu_result_q   <= alu_result_e_i;
        extended_imm_q <= extended_imm_e_i;
        pc_plus_q      <= pc_plus_e_i;
        reg_write_en_q <= reg_write_en_e_i;
        rd_idx_q       <= rd_idx_e_i;
        result_src_q   <= result_src_e_i;
      end
      if (load_fire) mem_read_data_q <= load_ext;
    end
  end

  assign load_bp    = load_fire ? load_ext : 32'd0;
  assign bypass_m_o = ({32{result_src_e_i[0]}} & alu_result_e_i)   |
                      ({32{result_src_e_i[1]}} & extended_imm_e_i) |
                      ({32{result_src_e_i[2]}} & load_bp)          |
                      ({32{result_src_e_i[3]}} & pc_plus_e_i);

  assign fault_addr_o      = fault_addr_q;
  assign mem_read_data_m_o = mem_read_data_q;
  assign alu_result_m_o    = alu_result_q;
  assign extended_imm_m_o  = extended_imm_q;
  assign pc_plus_m_o       = pc_plus_q;
  assign reg_write_en_m_o  = reg_write_en_q;
  assign rd_idx_m_o        = rd_idx_q;
  assign result_src_m_o    = result_src_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: ALU pass-through, store lanes, load latency/extension,
// misalign and timeout faults, reset during an outstanding load.
`timescale 1ns/1ps
module tb_lsu_mem_stage;

  localparam logic [3:0] DMEM_NO  = 4'd0;
  localparam logic [3:0] DMEM_LB  = 4'd1;
  localparam logic [3:0] DMEM_LH  = 4'd2;
  localparam logic [3:0] DMEM_LW  = 4'd3;
  localparam logic [3:0] DMEM_LBU = 4'd4;
  localparam logic [3:0] DMEM_LHU = 4'd5;
  localparam logic [3:0] DMEM_SB  = 4'd6;
  localparam logic [3:0] DMEM_SH  = 4'd7;
  localparam logic [3:0] DMEM_SW  = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result_e, alu_calc_e, rs2_e, imm_e, pc_plus_e;
  logic [3:0]  dmem_type_e, result_src_e;
  logic        reg_we_e;
  logic [4:0]  rd_e;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        stall, fault;
  logic [31:0] fault_addr, mem_rd_m, alu_m, imm_m, pc_m, bypass;
  logic        reg_we_m;
  logic [4:0]  rd_m;
  logic [3:0]  rs_m;

  int n_assert = 0;
  int n_fail   = 0;

  lsu_mem_stage #(
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(4),
    .MISALIGN_FAULT(1'b1)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .alu_result_e_i     (alu_result_e),
    .alu_calculation_e_i(alu_calc_e),
    .dmem_type_e_i      (dmem_type_e),
    .rs2_e_i            (rs2_e),
    .extended_imm_e_i   (imm_e),
    .pc_plus_e_i        (pc_plus_e),
    .reg_write_en_e_i   (reg_we_e),
    .rd_idx_e_i         (rd_e),
    .result_src_e_i     (result_src_e),
    .bus_req_o          (bus_req),
    .bus_we_o           (bus_we),
    .bus_addr_o         (bus_addr),
    .bus_be_o           (bus_be),
    .bus_wdata_o        (bus_wdata),
    .bus_gnt_i          (bus_gnt),
    .bus_rvalid_i       (bus_rvalid),
    .bus_rdata_i        (bus_rdata),
    .stall_o            (stall),
    .fault_o            (fault),
    .fault_addr_o       (fault_addr),
    .mem_read_data_m_o  (mem_rd_m),
    .alu_result_m_o     (alu_m),
    .extended_imm_m_o   (imm_m),
    .pc_plus_m_o        (pc_m),
    .reg_write_en_m_o   (reg_we_m),
    .rd_idx_m_o         (rd_m),
    .result_src_m_o     (rs_m),
    .bypass_m_o         (bypass)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    dmem_type_e  = DMEM_NO;
    alu_result_e = 32'd0;
    alu_calc_e   = 32'd0;
    rs2_e        = 32'd0;
    imm_e        = 32'd0;
    pc_plus_e    = 32'd0;
    reg_we_e     = 1'b0;
    rd_e         = 5'd0;
    result_src_e = 4'd0;
    bus_gnt      = 1'b0;
    bus_rvalid   = 1'b0;
    bus_rdata    = 32'd0;
  endtask

  // Load of dmem_type at addr, gnt in issue cycle, rvalid k cycles later.
  task automatic run_load(input string tag, input logic [3:0] typ, input logic [31:0] a,
                          input logic [31:0] rdata, input int k, input logic [31:0] exp);
    dmem_type_e  = typ;
    alu_calc_e   = a;
    reg_we_e     = 1'b1;
    rd_e         = 5'd7;
    result_src_e = 4'b0100;
    bus_gnt      = 1'b1;
    #1;
    chk({tag, "_req"}, 32'(bus_req), 32'd1);
    chk({tag, "_we"}, 32'(bus_we), 32'd0);
    for (int i = 0; i < k; i++) begin
      chk({tag, "_stall"}, 32'(stall), 32'd1);
      tick();
      bus_gnt = 1'b0;
      if (i == k - 1) begin
        bus_rvalid = 1'b1;
        bus_rdata  = rdata;
      end
      #1;
      chk({tag, "_wb_bubble"}, 32'(reg_we_m), 32'd0);
    end
    chk({tag, "_stall_rv"}, 32'(stall), 32'd0);
    chk({tag, "_bypass"}, bypass, exp);
    tick();
    drive_idle();
    #1;
    chk({tag, "_data"}, mem_rd_m, exp);
    chk({tag, "_wb_we"}, 32'(reg_we_m), 32'd1);
    chk({tag, "_rd"}, 32'(rd_m), 32'd7);
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_alu_m", alu_m, 32'd0);
    chk("rst_we_m", 32'(reg_we_m), 32'd0);
    chk("rst_mem_m", mem_rd_m, 32'd0);

    // Non-memory ALU op, gnt asserted but irrelevant
    dmem_type_e  = DMEM_NO;
    alu_result_e = 32'h1234;
    rd_e         = 5'd5;
    reg_we_e     = 1'b1;
    result_src_e = 4'b0001;
    bus_gnt      = 1'b1;
    #1;
    chk("alu_stall", 32'(stall), 32'd0);
    chk("alu_req", 32'(bus_req), 32'd0);
    chk("alu_bypass", bypass, 32'h1234);
    tick();
    drive_idle();
    #1;
    chk("alu_m", alu_m, 32'h1234);
    chk("alu_we_m", 32'(reg_we_m), 32'd1);
    chk("alu_rd_m", 32'(rd_m), 32'd5);
    chk("alu_rs_m", 32'(rs_m), 32'd1);

    // SB to byte 3, granted immediately
    dmem_type_e = DMEM_SB;
    alu_calc_e  = 32'h103;
    rs2_e       = 32'h0000_00AB;
    bus_gnt     = 1'b1;
    pc_plus_e   = 32'h44;
    #1;
    chk("sb_req", 32'(bus_req), 32'd1);
    chk("sb_we", 32'(bus_we), 32'd1);
    chk("sb_be", 32'(bus_be), 32'b1000);
    chk("sb_addr", bus_addr, 32'h100);
    chk("sb_wdata", bus_wdata, 32'hABAB_ABAB);
    chk("sb_stall", 32'(stall), 32'd0);
    tick();
    drive_idle();
    #1;
    chk("sb_pc_m", pc_m, 32'h44);

    // SH to upper halfword
    dmem_type_e = DMEM_SH;
    alu_calc_e  = 32'h106;
    rs2_e       = 32'h1234_CAFE;
    bus_gnt     = 1'b1;
    #1;
    chk("sh_be", 32'(bus_be), 32'b1100);
    chk("sh_wdata", bus_wdata, 32'hCAFE_CAFE);
    chk("sh_addr", bus_addr, 32'h104);
    chk("sh_stall", 32'(stall), 32'd0);
    tick();
    drive_idle();
    #1;

    run_load("lb", DMEM_LB, 32'h101, 32'h0000_8000, 3, 32'hFFFF_FF80);
    run_load("lbu", DMEM_LBU, 32'h101, 32'h0000_8000, 3, 32'h0000_0080);
    run_load("lh", DMEM_LH, 32'h102, 32'h8001_0000, 1, 32'hFFFF_8001);
    run_load("lhu", DMEM_LHU, 32'h102, 32'h8001_0000, 2, 32'h0000_8001);

    // rvalid while idle must not touch the M register
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hFFFF_FFFF;
    tick();
    bus_rvalid = 1'b0;
    #1;
    chk("idle_rvalid", mem_rd_m, 32'h0000_8001);

    // Misaligned LW faults without a bus request
    dmem_type_e = DMEM_LW;
    alu_calc_e  = 32'h102;
    reg_we_e    = 1'b1;
    rd_e        = 5'd3;
    bus_gnt     = 1'b1;
    #1;
    chk("mis_req", 32'(bus_req), 32'd0);
    chk("mis_stall", 32'(stall), 32'd1);
    chk("mis_nofault", 32'(fault), 32'd0);
    tick();
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_addr", fault_addr, 32'h102);
    chk("mis_req2", 32'(bus_req), 32'd0);
    chk("mis_stall2", 32'(stall), 32'd0);
    chk("mis_we_m", 32'(reg_we_m), 32'd0);
    tick();
    drive_idle();
    #1;
    chk("mis_fault_end", 32'(fault), 32'd0);
    chk("mis_we_m2", 32'(reg_we_m), 32'd0);

    // SW never granted: 4 stall cycles then a timeout fault
    dmem_type_e = DMEM_SW;
    alu_calc_e  = 32'h200;
    rs2_e       = 32'hDEAD_BEEF;
    reg_we_e    = 1'b1;
    #1;
    chk("to_be", 32'(bus_be), 32'b1111);
    chk("to_wdata", bus_wdata, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      chk("to_stall", 32'(stall), 32'd1);
      chk("to_req", 32'(bus_req), 32'd1);
      chk("to_nofault", 32'(fault), 32'd0);
      tick();
    end
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_req_drop", 32'(bus_req), 32'd0);
    chk("to_stall_drop", 32'(stall), 32'd0);
    chk("to_addr", fault_addr, 32'h200);
    tick();
    drive_idle();
    alu_result_e = 32'h55;
    reg_we_e     = 1'b1;
    #1;
    chk("to_resume_fault", 32'(fault), 32'd0);
    chk("to_resume_stall", 32'(stall), 32'd0);
    chk("to_we_m", 32'(reg_we_m), 32'd0);
    tick();
    drive_idle();
    #1;
    chk("to_resume_alu", alu_m, 32'h55);

    // Reset while a load waits in RESP; late rvalid is dropped
    dmem_type_e  = DMEM_LW;
    alu_calc_e   = 32'h300;
    reg_we_e     = 1'b1;
    rd_e         = 5'd9;
    result_src_e = 4'b0100;
    bus_gnt      = 1'b1;
    tick();
    bus_gnt = 1'b0;
    #1;
    chk("rr_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    drive_idle();
    tick();
    reset      = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h1111_1111;
    #1;
    chk("rr_stall2", 32'(stall), 32'd0);
    chk("rr_req", 32'(bus_req), 32'd0);
    tick();
    bus_rvalid = 1'b0;
    #1;
    chk("rr_we_m", 32'(reg_we_m), 32'd0);
    chk("rr_mem_m", mem_rd_m, 32'd0);
    chk("rr_alu_m", alu_m, 32'd0);
    chk("rr_faddr", fault_addr, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Parametrised successor to the single-cycle, fixed-latency MEM stage. Performs RV32 load/store through a req/gnt/rvalid data bus with variable latency.
- Stalls the pipeline while an access is in flight.
- Detects misaligned and timed-out accesses and raises a fault.
- Drives the MEM→WB pipeline register and the E-stage bypass value.

Parameters:
ADDR_WIDTH, 32, byte-address width driven on the bus (2..32).
TIMEOUT_CYCLES, 255, cycles an access may wait for gnt or rvalid before faulting; 0 disables the timeout.
MISALIGN_FAULT, 1, 1: misaligned LH/LHU/LW/SH/SW fault; 0: they are issued with the address forced to halfword/word alignment.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
alu_result_e_i  in  32  result for WB (non-memory ops)
alu_calculation_e_i  in  32  effective address
dmem_type_e_i  in  4  DMEM_* encoding from definitions.vh
rs2_e_i  in  32  store data
extended_imm_e_i  in  32  imm for lui
pc_plus_e_i  in  32  pc+4
reg_write_en_e_i  in  1  RF write enable
rd_idx_e_i  in  5  rd
result_src_e_i  in  4  one-hot WB source select
bus_req_o  out  1  access request
bus_we_o  out  1  1=store
bus_addr_o  out  ADDR_WIDTH  word-aligned address
bus_be_o  out  4  byte enables
bus_wdata_o  out  32  lane-aligned store data
bus_gnt_i  in  1  request accepted
bus_rvalid_i  in  1  load data valid
bus_rdata_i  in  32  load data
stall_o  out  1  hold upstream stages
fault_o  out  1  1-cycle pulse: misalign or timeout
fault_addr_o  out  32  address of faulting access
mem_read_data_m_o, alu_result_m_o, extended_imm_m_o, pc_plus_m_o  out  32 each  to WB
reg_write_en_m_o  out  1;  rd_idx_m_o  out  5;  result_src_m_o  out  4  to WB
bypass_m_o  out  32  forwarding value (combinational)

Behaviour:
- Reset: all registered outputs 0, FSM=IDLE, timeout counter 0. Combinational outputs are then 0 (bus_req_o=0, stall_o=0).
- mem_op = dmem_type_e_i != DMEM_NO.
- misalign: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
- Store lanes:
  - SB: data replicated to all lanes; be = 1<<addr[1:0].
  - SH: data in halfword addr[1]; be = 0011 or 1100.
  - SW: be = 1111.
- bus_addr_o = {addr[ADDR_WIDTH-1:2],2'b00}.
- FSM states:
  - IDLE:
    - mem_op and not faulting: bus_req_o=1. On gnt: store→stays IDLE, access complete; load→RESP.
    - No gnt: stall_o=1, request held (inputs frozen by stall).
    - No mem_op: stall_o=0.
  - RESP: stall_o=1 until bus_rvalid_i. On that cycle stall_o=0, FSM→IDLE. Load data is sign/zero-extended from lane addr[1:0] (LB/LBU/LH/LHU/LW) and registered into mem_read_data_m_o at that edge.
  - FAULT: entered on misalign (no bus_req_o issued) or timeout. One cycle. fault_o=1, fault_addr_o=address, stall_o=0, M register loaded as bubble. Next state IDLE.
- bus_req_o may only drop after gnt or on timeout. A rvalid seen in IDLE is ignored.
- Latency:
  - Store with gnt in the issue cycle: 0 stall cycles.
  - Load with gnt at cycle t and rvalid at t+k: stall for k cycles.
  - Non-memory op: 1 cycle, identical to a plain pipeline register.
- Pipeline register:
  - stall_o=0: capture all *_e_i.
  - stall_o=1: load a bubble (reg_write_en_m_o=0, result_src_m_o=0, other fields held).
  - Faulting access: bubble.
- Timeout counter:
  - Counts every cycle in IDLE-with-request-pending and in RESP; cleared on gnt, rvalid or entry to IDLE.
  - Reaching TIMEOUT_CYCLES → FAULT.
  - A timed-out load's late rvalid is ignored.
- bypass_m_o = OR of one-hot result_src_e_i selections of alu_result_e_i, extended_imm_e_i, extended load data (valid only on the rvalid cycle) and pc_plus_e_i.
- Reset asserted mid-access: FSM→IDLE immediately and bus_req_o drops the next cycle. A pending rvalid is discarded.

Test Plan:
- Non-memory ALU op 0x1234, rd=5, gnt unused → next cycle alu_result_m_o=0x1234, reg_write_en_m_o=1, stall_o never 1.
- SB rs2=0x000000AB, addr=0x103, gnt same cycle → bus_be_o=1000, bus_addr_o=0x100, bus_wdata_o[31:24]=0xAB, no stall.
- LB addr=0x101, gnt at t, rdata=0x0000_8000 at t+3 → stall_o high 3 cycles, mem_read_data_m_o=0xFFFFFF80. Same access as LBU → 0x00000080.
- LW addr=0x102, MISALIGN_FAULT=1 → no bus_req_o, fault_o pulse, fault_addr_o=0x102, reg_write_en_m_o=0.
- TIMEOUT_CYCLES=4, gnt never asserted → stall 4 cycles, then fault_o=1, bus_req_o=0, pipeline resumes.
- Load in RESP, reset pulsed, rvalid arrives after → outputs all 0, stall_o=0, no write-back.
